// File: rtl/fib_lookup_engine_pkg.sv
// Shared definitions for the FIB lookup engine.
//   NUM_PORTS / MAC_SZ : default bridge port count and MAC width
//   MCAST_BIT          : group (multicast/broadcast) bit of a MAC address
//   field offsets      : layout of lq_data = {src_port, sa, da}, da in the LSBs
//   fib_state_e        : lookup FSM state encoding
package fib_lookup_engine_pkg;

    localparam int unsigned NUM_PORTS  = 4;
    localparam int unsigned MAC_SZ     = 48;
    localparam int unsigned MCAST_BIT  = 40;
    localparam int unsigned FLD_DA_LSB = 0;

    // Source MAC sits directly above the destination MAC.
    function automatic int unsigned fld_sa_lsb(input int unsigned msz);
        return msz;
    endfunction

    // Source port sits above both MAC fields.
    function automatic int unsigned fld_src_lsb(input int unsigned msz);
        return 2 * msz;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_LEARN  = 2'd2,
        ST_RESP   = 2'd3
    } fib_state_e;

endpackage

// File: rtl/fib_cam.sv
// Fully-associative FIB storage: entries x {valid, mac, port}.
//   sa_key/da_key   : keys for the two parallel compare ports
//   sa_hit_c/idx_c  : SA match and its entry index (lowest index wins)
//   da_hit_c/port_c : DA match and the stored port (lowest index wins)
//   first_inv_c     : lowest-index invalid entry; any_inv_c when one exists
//   we/wr_*         : single write port, sets the entry valid
//   flush           : clears every valid bit; wins over a same-cycle write
module fib_cam
    import fib_lookup_engine_pkg::*;
#(
    parameter int unsigned entries = 16,
    parameter int unsigned mac_sz  = MAC_SZ,
    parameter int unsigned pw      = 2,
    localparam int unsigned iw     = $clog2(entries)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [mac_sz-1:0] sa_key,
    input  logic [mac_sz-1:0] da_key,
    output logic              sa_hit_c,
    output logic [iw-1:0]     sa_idx_c,
    output logic              da_hit_c,
    output logic [pw-1:0]     da_port_c,
    output logic [iw-1:0]     first_inv_c,
    output logic              any_inv_c,
    input  logic              we,
    input  logic [iw-1:0]     wr_idx,
    input  logic [mac_sz-1:0] wr_mac,
    input  logic [pw-1:0]     wr_port,
    input  logic              flush
);

    logic [entries-1:0] valid;
    logic [mac_sz-1:0]  mac  [entries];
    logic [pw-1:0]      port [entries];

    // Valid bits: the only state that needs a defined reset value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Entry payload; contents of invalid entries are don't-care.
    always_ff @(posedge clk) begin
        if (we && !flush) begin
            mac[wr_idx]  <= wr_mac;
            port[wr_idx] <= wr_port;
        end
    end

    // Parallel compares; scanning downward lets the lowest index win.
    always_comb begin
        sa_hit_c    = 1'b0;
        sa_idx_c    = '0;
        da_hit_c    = 1'b0;
        da_port_c   = '0;
        first_inv_c = '0;
        any_inv_c   = 1'b0;
        for (int i = int'(entries) - 1; i >= 0; i--) begin
            if (valid[i] && (mac[i] == sa_key)) begin
                sa_hit_c = 1'b1;
                sa_idx_c = iw'(i);
            end
            if (valid[i] && (mac[i] == da_key)) begin
                da_hit_c  = 1'b1;
                da_port_c = port[i];
            end
            if (!valid[i]) begin
                any_inv_c   = 1'b1;
                first_inv_c = iw'(i);
            end
        end
    end

endmodule

// File: rtl/fib_lookup_engine.sv
// FIB lookup responder: one request per frame, learns SA->port, returns a
// destination port mask.
//   clk, reset_n              : clock, async active-low reset
//   lq_srdy/lq_drdy/lq_data   : request {src_port, sa, da}
//   lr_srdy/lr_drdy/lr_data   : response, num_ports-wide destination mask
//   flush                     : pulse, invalidates the whole table
module fib_lookup_engine
    import fib_lookup_engine_pkg::*;
#(
    parameter int unsigned num_ports = NUM_PORTS,
    parameter int unsigned entries   = 16,
    parameter int unsigned mac_sz    = MAC_SZ,
    localparam int unsigned pw       = (num_ports > 1) ? $clog2(num_ports) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   lq_srdy,
    output logic                   lq_drdy,
    input  logic [pw+2*mac_sz-1:0] lq_data,
    output logic                   lr_srdy,
    input  logic                   lr_drdy,
    output logic [num_ports-1:0]   lr_data,
    input  logic                   flush
);

    localparam int unsigned iw      = $clog2(entries);
    localparam int unsigned sa_lsb  = fld_sa_lsb(mac_sz);
    localparam int unsigned src_lsb = fld_src_lsb(mac_sz);

    fib_state_e state, state_nxt;

    logic [pw-1:0]     src_q;
    logic [mac_sz-1:0] sa_q, da_q;
    logic              sa_hit_q, any_inv_q;
    logic [iw-1:0]     sa_idx_q, first_inv_q, rp;

    logic              sa_hit_c, da_hit_c, any_inv_c;
    logic [iw-1:0]     sa_idx_c, first_inv_c;
    logic [pw-1:0]     da_port_c;

    logic                 capture_c, lookup_c, cam_we_c, rp_adv_c, learn_ok_c;
    logic [iw-1:0]        wr_idx_c;
    logic [num_ports-1:0] mask_c, excl_c;

    fib_cam #(
        .entries (entries),
        .mac_sz  (mac_sz),
        .pw      (pw)
    ) u_cam (
        .clk         (clk),
        .reset_n     (reset_n),
        .sa_key      (sa_q),
        .da_key      (da_q),
        .sa_hit_c    (sa_hit_c),
        .sa_idx_c    (sa_idx_c),
        .da_hit_c    (da_hit_c),
        .da_port_c   (da_port_c),
        .first_inv_c (first_inv_c),
        .any_inv_c   (any_inv_c),
        .we          (cam_we_c),
        .wr_idx      (wr_idx_c),
        .wr_mac      (sa_q),
        .wr_port     (src_q),
        .flush       (flush)
    );

    // Group SAs and out-of-range source ports are never learned.
    assign learn_ok_c = !sa_q[MCAST_BIT] && (32'(src_q) < num_ports);

    // Destination mask rules in priority order.
    always_comb begin
        excl_c = ~(num_ports'(1) << src_q);
        mask_c = excl_c;
        if (32'(src_q) >= num_ports) begin
            mask_c = '0;
        end else if (da_q[MCAST_BIT]) begin
            mask_c = excl_c;
        end else if (da_hit_c && (da_port_c == src_q)) begin
            mask_c = '0;
        end else if (da_hit_c) begin
            mask_c = num_ports'(1) << da_port_c;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_nxt = state;
        capture_c = 1'b0;
        lookup_c  = 1'b0;
        cam_we_c  = 1'b0;
        rp_adv_c  = 1'b0;
        wr_idx_c  = rp;
        case (state)
            ST_IDLE: begin
                if (lq_srdy && lq_drdy) begin
                    capture_c = 1'b1;
                    state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                lookup_c  = 1'b1;
                state_nxt = ST_LEARN;
            end
            ST_LEARN: begin
                state_nxt = ST_RESP;
                if (learn_ok_c) begin
                    cam_we_c = 1'b1;
                    if (sa_hit_q) begin
                        wr_idx_c = sa_idx_q;
                    end else if (any_inv_q) begin
                        wr_idx_c = first_inv_q;
                    end else begin
                        wr_idx_c = rp;
                        rp_adv_c = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (lr_srdy && lr_drdy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, handshake outputs, holding registers and replacement pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            lq_drdy     <= 1'b1;
            lr_srdy     <= 1'b0;
            lr_data     <= '0;
            src_q       <= '0;
            sa_q        <= '0;
            da_q        <= '0;
            sa_hit_q    <= 1'b0;
            sa_idx_q    <= '0;
            first_inv_q <= '0;
            any_inv_q   <= 1'b0;
            rp          <= '0;
        end else begin
            state   <= state_nxt;
            lq_drdy <= (state_nxt == ST_IDLE);
            lr_srdy <= (state_nxt == ST_RESP);
            if (capture_c) begin
                src_q <= lq_data[src_lsb +: pw];
                sa_q  <= lq_data[sa_lsb +: mac_sz];
                da_q  <= lq_data[FLD_DA_LSB +: mac_sz];
            end
            // Results come from the pre-learn table and are frozen for LEARN.
            if (lookup_c) begin
                lr_data     <= mask_c;
                sa_hit_q    <= sa_hit_c;
                sa_idx_q    <= sa_idx_c;
                first_inv_q <= first_inv_c;
                any_inv_q   <= any_inv_c;
            end
            if (flush) begin
                rp <= '0;
            end else if (rp_adv_c) begin
                rp <= rp + iw'(1);
            end
        end
    end

endmodule

// File: tb/tb_fib_lookup_engine.sv
module tb_fib_lookup_engine;

    localparam logic [47:0] MAC_A = 48'h00000000000A;
    localparam logic [47:0] MAC_B = 48'h00000000000B;
    localparam logic [47:0] MAC_C = 48'h00000000000C;
    localparam logic [47:0] MAC_D = 48'h00000000000D;
    localparam logic [47:0] MAC_E = 48'h00000000000E;
    localparam logic [47:0] PROBE = 48'h010000000099;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] MC_SA = 48'h01005E000001;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        lq_srdy, lq_drdy, lr_srdy, lr_drdy, flush;
    logic [97:0] lq_data;
    logic [3:0]  lr_data;

    logic        lq3_srdy, lq3_drdy, lr3_srdy, lr3_drdy;
    logic [97:0] lq3_data;
    logic [2:0]  lr3_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fib_lookup_engine #(.num_ports(4), .entries(16), .mac_sz(48)) dut (
        .clk(clk), .reset_n(reset_n),
        .lq_srdy(lq_srdy), .lq_drdy(lq_drdy), .lq_data(lq_data),
        .lr_srdy(lr_srdy), .lr_drdy(lr_drdy), .lr_data(lr_data),
        .flush(flush)
    );

    fib_lookup_engine #(.num_ports(3), .entries(16), .mac_sz(48)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .lq_srdy(lq3_srdy), .lq_drdy(lq3_drdy), .lq_data(lq3_data),
        .lr_srdy(lr3_srdy), .lr_drdy(lr3_drdy), .lr_data(lr3_data),
        .flush(1'b0)
    );

    // One full request/response on the 4-port instance with lr_drdy high.
    task automatic run_req(input logic [1:0] src, input logic [47:0] sa, input logic [47:0] da,
                           input bit flush_learn, output logic [3:0] mask, output int lat);
        mask = 'x;
        lat  = -1;
        @(negedge clk);
        lq_data = {src, sa, da};
        lq_srdy = 1'b1;
        for (int i = 0; i < 20 && !lq_drdy; i++) @(negedge clk);
        @(posedge clk);
        #1 lq_srdy = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (flush_learn && i == 2) flush = 1'b1;
            else flush = 1'b0;
            if (lr_srdy) begin
                mask = lr_data;
                lat  = i;
                break;
            end
        end
        flush = 1'b0;
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL resp_timeout got no lr_srdy exp lr_srdy within 20 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    // Same sequence on the 3-port instance.
    task automatic run_req3(input logic [1:0] src, input logic [47:0] sa, input logic [47:0] da,
                            output logic [2:0] mask);
        int lat;
        mask = 'x;
        lat  = -1;
        @(negedge clk);
        lq3_data = {src, sa, da};
        lq3_srdy = 1'b1;
        for (int i = 0; i < 20 && !lq3_drdy; i++) @(negedge clk);
        @(posedge clk);
        #1 lq3_srdy = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (lr3_srdy) begin
                mask = lr3_data;
                lat  = i;
                break;
            end
        end
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL resp3_timeout got no lr_srdy exp lr_srdy within 20 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        lq_srdy = 1'b0; lq_data = '0; lr_drdy = 1'b1; flush = 1'b0;
        lq3_srdy = 1'b0; lq3_data = '0; lr3_drdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (lq_drdy !== 1'b1) begin errors++; $display("FAIL rst_lq_drdy got %b exp 1", lq_drdy); end
        checks++; if (lr_srdy !== 1'b0) begin errors++; $display("FAIL rst_lr_srdy got %b exp 0", lr_srdy); end
        checks++; if (lr_data !== 4'b0000) begin errors++; $display("FAIL rst_lr_data got %b exp 0000", lr_data); end
        checks++; if (dut.u_cam.valid !== 16'h0000) begin errors++; $display("FAIL rst_valid got %h exp 0000", dut.u_cam.valid); end
        reset_n = 1'b1;
    endtask

    task automatic test_learn_flood();
        logic [3:0] m; int lat;
        run_req(2'd1, MAC_A, MAC_B, 1'b0, m, lat);
        checks++; if (m !== 4'b1101) begin errors++; $display("FAIL flood_empty got %b exp 1101", m); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL latency got %0d exp 3", lat); end
        checks++; if (dut.u_cam.valid !== 16'h0001) begin errors++; $display("FAIL learn_first got %h exp 0001", dut.u_cam.valid); end
    endtask

    task automatic test_forward();
        logic [3:0] m; int lat;
        run_req(2'd2, MAC_B, MAC_A, 1'b0, m, lat);
        checks++; if (m !== 4'b0010) begin errors++; $display("FAIL fwd_a_from2 got %b exp 0010", m); end
        run_req(2'd3, MAC_C, MAC_A, 1'b0, m, lat);
        checks++; if (m !== 4'b0010) begin errors++; $display("FAIL fwd_a_from3 got %b exp 0010", m); end
        run_req(2'd1, MAC_D, MAC_A, 1'b0, m, lat);
        checks++; if (m !== 4'b0000) begin errors++; $display("FAIL filter_same_port got %b exp 0000", m); end
    endtask

    task automatic test_multicast();
        logic [3:0] m; int lat;
        run_req(2'd0, PROBE, BCAST, 1'b0, m, lat);
        checks++; if (m !== 4'b1110) begin errors++; $display("FAIL bcast got %b exp 1110", m); end
        run_req(2'd2, MC_SA, MAC_B, 1'b0, m, lat);
        checks++; if (m !== 4'b0000) begin errors++; $display("FAIL mc_sa_filter got %b exp 0000", m); end
        checks++; if (dut.u_cam.valid !== 16'h000F) begin errors++; $display("FAIL mc_no_learn got %h exp 000f", dut.u_cam.valid); end
    endtask

    task automatic test_station_move();
        logic [3:0] m; int lat;
        run_req(2'd3, MAC_A, MAC_E, 1'b0, m, lat);
        checks++; if (m !== 4'b0111) begin errors++; $display("FAIL move_flood got %b exp 0111", m); end
        checks++; if (dut.u_cam.valid !== 16'h000F) begin errors++; $display("FAIL move_no_new got %h exp 000f", dut.u_cam.valid); end
        run_req(2'd0, PROBE, MAC_A, 1'b0, m, lat);
        checks++; if (m !== 4'b1000) begin errors++; $display("FAIL move_new_port got %b exp 1000", m); end
    endtask

    task automatic test_fill_evict();
        logic [3:0] m; int lat;
        for (int k = 0; k < 12; k++) begin
            run_req(2'd0, 48'h100 + 48'(k), MAC_E, 1'b0, m, lat);
            checks++; if (m !== 4'b1110) begin errors++; $display("FAIL fill_%0d got %b exp 1110", k, m); end
        end
        checks++; if (dut.u_cam.valid !== 16'hFFFF) begin errors++; $display("FAIL full got %h exp ffff", dut.u_cam.valid); end
        run_req(2'd2, 48'h200, MAC_E, 1'b0, m, lat);
        checks++; if (m !== 4'b1011) begin errors++; $display("FAIL sa17 got %b exp 1011", m); end
        checks++; if (dut.rp !== 4'd1) begin errors++; $display("FAIL rp_after17 got %0d exp 1", dut.rp); end
        run_req(2'd0, PROBE, MAC_A, 1'b0, m, lat);
        checks++; if (m !== 4'b1110) begin errors++; $display("FAIL evicted_a got %b exp 1110", m); end
        run_req(2'd0, PROBE, 48'h200, 1'b0, m, lat);
        checks++; if (m !== 4'b0100) begin errors++; $display("FAIL new_200 got %b exp 0100", m); end
        run_req(2'd0, PROBE, MAC_B, 1'b0, m, lat);
        checks++; if (m !== 4'b0100) begin errors++; $display("FAIL kept_b got %b exp 0100", m); end
        run_req(2'd1, 48'h201, MAC_E, 1'b0, m, lat);
        checks++; if (m !== 4'b1101) begin errors++; $display("FAIL sa18 got %b exp 1101", m); end
        run_req(2'd0, PROBE, MAC_B, 1'b0, m, lat);
        checks++; if (m !== 4'b1110) begin errors++; $display("FAIL evicted_b got %b exp 1110", m); end
        run_req(2'd0, PROBE, MAC_C, 1'b0, m, lat);
        checks++; if (m !== 4'b1000) begin errors++; $display("FAIL kept_c got %b exp 1000", m); end
        run_req(2'd0, PROBE, 48'h201, 1'b0, m, lat);
        checks++; if (m !== 4'b0010) begin errors++; $display("FAIL new_201 got %b exp 0010", m); end
        run_req(2'd0, PROBE, 48'h100, 1'b0, m, lat);
        checks++; if (m !== 4'b0000) begin errors++; $display("FAIL filter_100 got %b exp 0000", m); end
    endtask

    task automatic test_backpressure();
        int seen;
        seen = 0;
        lr_drdy = 1'b0;
        @(negedge clk);
        lq_data = {2'd1, PROBE, MAC_C};
        lq_srdy = 1'b1;
        @(posedge clk);
        #1 lq_srdy = 1'b0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (lr_srdy) seen = 1;
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL bp_timeout got no lr_srdy exp lr_srdy"); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (lr_data !== 4'b1000) begin errors++; $display("FAIL bp_data cyc %0d got %b exp 1000", c, lr_data); end
            checks++; if (lr_srdy !== 1'b1) begin errors++; $display("FAIL bp_srdy cyc %0d got %b exp 1", c, lr_srdy); end
            checks++; if (lq_drdy !== 1'b0) begin errors++; $display("FAIL bp_lq_drdy cyc %0d got %b exp 0", c, lq_drdy); end
            @(negedge clk);
        end
        lr_drdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (lr_srdy !== 1'b0) begin errors++; $display("FAIL bp_release_srdy got %b exp 0", lr_srdy); end
        checks++; if (lq_drdy !== 1'b1) begin errors++; $display("FAIL bp_release_drdy got %b exp 1", lq_drdy); end
    endtask

    task automatic test_flush_learn();
        logic [3:0] m; int lat;
        run_req(2'd2, 48'h300, MAC_C, 1'b1, m, lat);
        checks++; if (m !== 4'b1000) begin errors++; $display("FAIL flush_resp got %b exp 1000", m); end
        checks++; if (dut.u_cam.valid !== 16'h0000) begin errors++; $display("FAIL flush_valid got %h exp 0000", dut.u_cam.valid); end
        checks++; if (dut.rp !== 4'd0) begin errors++; $display("FAIL flush_rp got %0d exp 0", dut.rp); end
        run_req(2'd0, PROBE, MAC_C, 1'b0, m, lat);
        checks++; if (m !== 4'b1110) begin errors++; $display("FAIL flush_probe got %b exp 1110", m); end
    endtask

    task automatic test_bad_port();
        logic [2:0] m;
        run_req3(2'd3, MAC_A, MAC_B, m);
        checks++; if (m !== 3'b000) begin errors++; $display("FAIL bad_port_mask got %b exp 000", m); end
        checks++; if (dut3.u_cam.valid !== 16'h0000) begin errors++; $display("FAIL bad_port_learn got %h exp 0000", dut3.u_cam.valid); end
        run_req3(2'd1, MAC_A, MAC_B, m);
        checks++; if (m !== 3'b101) begin errors++; $display("FAIL p3_flood got %b exp 101", m); end
        run_req3(2'd2, PROBE, MAC_A, m);
        checks++; if (m !== 3'b010) begin errors++; $display("FAIL p3_fwd got %b exp 010", m); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] m; int lat; int seen;
        seen = 0;
        lr_drdy = 1'b0;
        @(negedge clk);
        lq_data = {2'd1, MAC_A, MAC_B};
        lq_srdy = 1'b1;
        @(posedge clk);
        #1 lq_srdy = 1'b0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (lr_srdy) seen = 1;
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL rmid_timeout got no lr_srdy exp lr_srdy"); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (lr_srdy !== 1'b0) begin errors++; $display("FAIL rmid_srdy got %b exp 0", lr_srdy); end
        checks++; if (lq_drdy !== 1'b1) begin errors++; $display("FAIL rmid_drdy got %b exp 1", lq_drdy); end
        checks++; if (lr_data !== 4'b0000) begin errors++; $display("FAIL rmid_data got %b exp 0000", lr_data); end
        checks++; if (dut.u_cam.valid !== 16'h0000) begin errors++; $display("FAIL rmid_valid got %h exp 0000", dut.u_cam.valid); end
        @(negedge clk);
        reset_n = 1'b1;
        lr_drdy = 1'b1;
        run_req(2'd1, MAC_A, MAC_B, 1'b0, m, lat);
        checks++; if (m !== 4'b1101) begin errors++; $display("FAIL post_reset got %b exp 1101", m); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_learn_flood();
        test_forward();
        test_multicast();
        test_station_move();
        test_fill_evict();
        test_backpressure();
        test_flush_learn();
        test_bad_port();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
